// File: rtl/acq_fifo_writer_if.sv
// FIFO write port of the acquisition writer: strobe and data towards the
// FIFO, full flag back from it.
interface acq_fifo_writer_if #(
  parameter int WIDTH = 8
);
  logic             FIFO_WR;
  logic [WIDTH-1:0] FIFO_DATA;
  logic             FIFO_FULL;

  // Writer side: drives the strobe and data, observes the full flag.
  modport master (
    output FIFO_WR,
    output FIFO_DATA,
    input  FIFO_FULL
  );

  // FIFO side: receives the strobe and data, reports the full flag.
  modport slave (
    input  FIFO_WR,
    input  FIFO_DATA,
    output FIFO_FULL
  );
endinterface

// File: rtl/acq_fifo_writer.sv
// Acquisition front end: decimates an ADC sample stream, collects a
// pre-trigger block, waits for a (possibly forced) trigger and then writes a
// fixed number of post-trigger samples into a FIFO. Writes the FIFO refuses
// are counted, never retried; capture length is in accepted samples.
module acq_fifo_writer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             WR_CLK,
  input  logic             WR_RST_N,
  input  logic             ARM,
  input  logic             ABORT,
  input  logic [CNT_W-1:0] DECIMATION,
  input  logic [CNT_W-1:0] PRE_COUNT,
  input  logic [CNT_W-1:0] POST_COUNT,
  input  logic             SAMPLE_VALID,
  input  logic [WIDTH-1:0] SAMPLE_DATA,
  input  logic             TRIG,
  input  logic             FORCE_TRIG,
  acq_fifo_writer_if.master fifo,
  output logic             BUSY,
  output logic             TRIGGERED,
  output logic             DONE,
  output logic             OVERFLOW,
  output logic [CNT_W-1:0] DROP_COUNT
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT_TRIG,
    ST_POST
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] dec_q;
  logic [CNT_W-1:0] pre_q;
  logic [CNT_W-1:0] post_q;
  logic [CNT_W-1:0] dec_cnt;
  logic [CNT_W-1:0] pre_cnt;
  logic [CNT_W-1:0] post_cnt;
  logic             force_seen;
  logic             done_q;
  logic             fifo_wr_q;
  logic [WIDTH-1:0] fifo_data_q;
  logic             overflow_q;
  logic [CNT_W-1:0] drop_cnt;

  logic             active;
  logic             accept;
  logic             trig_hit;
  logic             arm_ok;
  logic [CNT_W-1:0] post_eff;
  logic [CNT_W-1:0] pre_nxt;
  logic [CNT_W-1:0] post_nxt;

  // An aborting cycle accepts nothing, so no write follows an ABORT.
  assign active   = (state != ST_IDLE);
  assign accept   = active && SAMPLE_VALID && (dec_cnt == '0) && !ABORT;
  assign trig_hit = accept && (TRIG || FORCE_TRIG || force_seen);
  assign arm_ok   = (state == ST_IDLE) && ARM && !ABORT;
  // A post length of 0 still writes the trigger sample.
  assign post_eff = (post_q == '0) ? ONE : post_q;
  // Counters never exceed their target minus one, so the increment cannot
  // wrap even with an all-ones target.
  assign pre_nxt  = pre_cnt + ONE;
  assign post_nxt = post_cnt + ONE;

  // Capture sequencer: configuration latch, decimation and length counters.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; async reset puts each one in a known state.
  always_ff @(posedge WR_CLK or negedge WR_RST_N) begin
    if (!WR_RST_N) begin
      state      <= ST_IDLE;
      dec_q      <= '0;
      pre_q      <= '0;
      post_q     <= '0;
      dec_cnt    <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      force_seen <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == ST_IDLE) begin
        if (arm_ok) begin
          dec_q      <= DECIMATION;
          pre_q      <= PRE_COUNT;
          post_q     <= POST_COUNT;
          dec_cnt    <= '0;
          pre_cnt    <= '0;
          post_cnt   <= '0;
          force_seen <= 1'b0;
          state      <= ST_PRE;
        end
      end else if (ABORT) begin
        force_seen <= 1'b0;
        state      <= ST_IDLE;
      end else begin
        if (SAMPLE_VALID) begin
          dec_cnt <= (dec_cnt == '0) ? dec_q : dec_cnt - ONE;
        end
        case (state)
          ST_PRE: begin
            if (pre_q == '0) begin
              state <= ST_WAIT_TRIG;
            end else if (accept) begin
              pre_cnt <= pre_nxt;
              if (pre_nxt == pre_q) state <= ST_WAIT_TRIG;
            end
          end
          ST_WAIT_TRIG: begin
            if (trig_hit) begin
              post_cnt   <= ONE;
              force_seen <= 1'b0;
              if (post_eff == ONE) begin
                done_q <= 1'b1;
                state  <= ST_IDLE;
              end else begin
                state <= ST_POST;
              end
            end else if (FORCE_TRIG) begin
              force_seen <= 1'b1;
            end
          end
          ST_POST: begin
            if (accept) begin
              post_cnt <= post_nxt;
              if (post_nxt == post_eff) begin
                done_q <= 1'b1;
                state  <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // FIFO write port: one registered write per accepted sample, data held otherwise.
  always_ff @(posedge WR_CLK or negedge WR_RST_N) begin
    if (!WR_RST_N) begin
      fifo_wr_q   <= 1'b0;
      fifo_data_q <= '0;
    end else begin
      fifo_wr_q <= accept;
      if (accept) fifo_data_q <= SAMPLE_DATA;
    end
  end

  // Drop bookkeeping: sticky overflow and saturating drop counter, cleared by ARM.
  always_ff @(posedge WR_CLK or negedge WR_RST_N) begin
    if (!WR_RST_N) begin
      overflow_q <= 1'b0;
      drop_cnt   <= '0;
    end else if (arm_ok) begin
      overflow_q <= 1'b0;
      drop_cnt   <= '0;
    end else if (fifo_wr_q && fifo.FIFO_FULL) begin
      overflow_q <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + ONE;
    end
  end

  assign fifo.FIFO_WR   = fifo_wr_q;
  assign fifo.FIFO_DATA = fifo_data_q;
  assign BUSY           = (state != ST_IDLE);
  assign TRIGGERED      = (state == ST_POST);
  assign DONE           = done_q;
  assign OVERFLOW       = overflow_q;
  assign DROP_COUNT     = drop_cnt;

endmodule

// File: tb/tb_acq_fifo_writer.sv
// Directed bench for acq_fifo_writer: table-driven per-cycle vectors for the
// main capture flows, hand-written sequences for force, abort and reset.
module tb_acq_fifo_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm, abort, valid, trig, force_trig, full;
  logic [15:0] dec, pre, post;
  logic [7:0]  data;
  logic        busy, trgd, done, ovf;
  logic [15:0] drops;

  int n_tests = 0;
  int n_fail  = 0;

  acq_fifo_writer_if #(.WIDTH(8)) fifo_bus ();
  assign fifo_bus.FIFO_FULL = full;

  acq_fifo_writer #(.WIDTH(8), .CNT_W(16)) dut (
    .WR_CLK       (clk),
    .WR_RST_N     (rst_n),
    .ARM          (arm),
    .ABORT        (abort),
    .DECIMATION   (dec),
    .PRE_COUNT    (pre),
    .POST_COUNT   (post),
    .SAMPLE_VALID (valid),
    .SAMPLE_DATA  (data),
    .TRIG         (trig),
    .FORCE_TRIG   (force_trig),
    .fifo         (fifo_bus.master),
    .BUSY         (busy),
    .TRIGGERED    (trgd),
    .DONE         (done),
    .OVERFLOW     (ovf),
    .DROP_COUNT   (drops)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus and the outputs expected after its rising edge.
  typedef struct {
    logic       arm, abort, valid;
    logic [7:0] d;
    logic       trig, frc, full;
    logic       wr;
    logic [7:0] wd;
    logic       busy, trgd, done, ovf;
    logic [15:0] drops;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic a, input logic ab, input logic v,
                              input logic [7:0] d, input logic t, input logic f,
                              input logic fl, input logic w, input logic [7:0] wd,
                              input logic b, input logic tg, input logic dn,
                              input logic ov, input logic [15:0] dr);
    vec_t r;
    r.arm = a; r.abort = ab; r.valid = v; r.d = d; r.trig = t; r.frc = f;
    r.full = fl; r.wr = w; r.wd = wd; r.busy = b; r.trgd = tg; r.done = dn;
    r.ovf = ov; r.drops = dr;
    return r;
  endfunction

  function automatic logic [31:0] pack(input logic w, input logic [7:0] wd,
                                       input logic b, input logic tg,
                                       input logic dn, input logic ov,
                                       input logic [15:0] dr);
    return {3'b0, w, wd, b, tg, dn, ov, dr};
  endfunction

  function automatic logic [31:0] outs();
    return pack(fifo_bus.FIFO_WR, fifo_bus.FIFO_DATA, busy, trgd, done, ovf, drops);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    arm = 0; abort = 0; valid = 0; data = 8'h00; trig = 0; force_trig = 0; full = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      arm = tbl[i].arm; abort = tbl[i].abort; valid = tbl[i].valid;
      data = tbl[i].d; trig = tbl[i].trig; force_trig = tbl[i].frc; full = tbl[i].full;
      tick();
      check($sformatf("%s[%0d]", tag, i), outs(),
            pack(tbl[i].wr, tbl[i].wd, tbl[i].busy, tbl[i].trgd, tbl[i].done,
                 tbl[i].ovf, tbl[i].drops));
    end
    tbl.delete();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    dec = 0; pre = 0; post = 0;
    rst_n = 1'b0;
    #1;
    check("reset_async", outs(), 32'h0);
    tick();
    tick();
    check("reset_hold", outs(), 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic capture: no decimation, 4 pre samples, TRIG on samples 2 and 6.
    dec = 0; pre = 4; post = 3;
    //                  arm ab v  d     t  f  fl  wr wd    b  tg dn ov drops
    tbl.push_back(mk(1, 0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd1, 0, 0, 0, 1, 8'd1, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd2, 1, 0, 0, 1, 8'd2, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd3, 0, 0, 0, 1, 8'd3, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd4, 0, 0, 0, 1, 8'd4, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd5, 0, 0, 0, 1, 8'd5, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 8'd0, 0, 0, 0, 0, 8'd5, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd6, 1, 0, 0, 1, 8'd6, 1, 1, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd7, 0, 0, 0, 1, 8'd7, 1, 1, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd8, 0, 0, 0, 1, 8'd8, 0, 0, 1, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd9, 1, 0, 0, 0, 8'd8, 0, 0, 0, 0, 16'd0));
    run_table("basic");

    // Decimation by 3, PRE=0, POST=2; TRIG on unaccepted index 4 is ignored.
    do_reset();
    dec = 2; pre = 0; post = 2;
    tbl.push_back(mk(1, 0, 0, 8'd0,  0, 0, 0, 0, 8'd0, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd0,  0, 0, 0, 1, 8'd0, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd1,  0, 0, 0, 0, 8'd0, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd2,  0, 0, 0, 0, 8'd0, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd3,  0, 0, 0, 1, 8'd3, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd4,  1, 0, 0, 0, 8'd3, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd5,  0, 0, 0, 0, 8'd3, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd6,  1, 0, 0, 1, 8'd6, 1, 1, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd7,  0, 0, 0, 0, 8'd6, 1, 1, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd8,  0, 0, 0, 0, 8'd6, 1, 1, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd9,  0, 0, 0, 1, 8'd9, 0, 0, 1, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd10, 0, 0, 0, 0, 8'd9, 0, 0, 0, 0, 16'd0));
    run_table("decim");

    // FIFO full for the writes of samples 2..6: five drops, length unchanged,
    // next ARM clears the flags, ABORT in PRE returns to IDLE.
    do_reset();
    dec = 0; pre = 0; post = 6;
    tbl.push_back(mk(1, 0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd1, 0, 0, 0, 1, 8'd1, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd2, 1, 0, 0, 1, 8'd2, 1, 1, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'd3, 0, 0, 1, 1, 8'd3, 1, 1, 0, 1, 16'd1));
    tbl.push_back(mk(0, 0, 1, 8'd4, 0, 0, 1, 1, 8'd4, 1, 1, 0, 1, 16'd2));
    tbl.push_back(mk(0, 0, 1, 8'd5, 0, 0, 1, 1, 8'd5, 1, 1, 0, 1, 16'd3));
    tbl.push_back(mk(0, 0, 1, 8'd6, 0, 0, 1, 1, 8'd6, 1, 1, 0, 1, 16'd4));
    tbl.push_back(mk(0, 0, 1, 8'd7, 0, 0, 1, 1, 8'd7, 0, 0, 1, 1, 16'd5));
    tbl.push_back(mk(0, 0, 0, 8'd0, 0, 0, 0, 0, 8'd7, 0, 0, 0, 1, 16'd5));
    tbl.push_back(mk(1, 0, 0, 8'd0, 0, 0, 0, 0, 8'd7, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 1, 0, 8'd0, 0, 0, 0, 0, 8'd7, 0, 0, 0, 0, 16'd0));
    run_table("drop");

    // FORCE_TRIG in PRE is forgotten; in WAIT_TRIG it fires on the next accepted sample.
    do_reset();
    dec = 0; pre = 2; post = 1;
    arm = 1; tick(); arm = 0;
    force_trig = 1; tick(); force_trig = 0;
    valid = 1; data = 8'h11; tick();
    data = 8'h12; tick();
    data = 8'h14; tick();
    check("force_pre_ignored", outs(), pack(1, 8'h14, 1, 0, 0, 0, 16'd0));
    valid = 0; force_trig = 1; tick(); force_trig = 0;
    for (int i = 0; i < 10; i++) tick();
    check("force_wait_idle", outs(), pack(0, 8'h14, 1, 0, 0, 0, 16'd0));
    valid = 1; data = 8'h13; tick(); valid = 0;
    check("force_fires", outs(), pack(1, 8'h13, 0, 0, 1, 0, 16'd0));

    // ABORT in POST, then ARM together with ABORT: stays IDLE, no writes, no DONE.
    do_reset();
    dec = 0; pre = 0; post = 5;
    arm = 1; tick(); arm = 0;
    valid = 1; data = 8'h21; tick();
    data = 8'h22; trig = 1; tick(); trig = 0;
    data = 8'h23; tick();
    check("abort_in_post", outs(), pack(1, 8'h23, 1, 1, 0, 0, 16'd0));
    data = 8'h24; abort = 1; tick(); abort = 0;
    check("abort_idle", outs(), pack(0, 8'h23, 0, 0, 0, 0, 16'd0));
    arm = 1; abort = 1; data = 8'h25; tick(); arm = 0; abort = 0;
    check("arm_abort_idle", outs(), pack(0, 8'h23, 0, 0, 0, 0, 16'd0));
    data = 8'h26; trig = 1; tick(); tick(); valid = 0; trig = 0;
    check("abort_no_more", outs(), pack(0, 8'h23, 0, 0, 0, 0, 16'd0));

    // One-cycle reset during POST: everything clears, nothing written after release.
    do_reset();
    dec = 0; pre = 0; post = 5;
    arm = 1; tick(); arm = 0;
    valid = 1; data = 8'h31; tick();
    data = 8'h32; trig = 1; tick(); trig = 0;
    data = 8'h33; full = 1; tick(); full = 0;
    check("pre_reset_post", outs(), pack(1, 8'h33, 1, 1, 0, 1, 16'd1));
    data = 8'h34; rst_n = 1'b0;
    #1;
    check("reset_mid_post", outs(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    data = 8'h35; trig = 1; tick();
    check("reset_release", outs(), 32'h0);
    data = 8'h36; tick(); tick(); valid = 0; trig = 0;
    check("reset_no_write", outs(), 32'h0);
    arm = 1; tick(); arm = 0;
    check("rearm_after_reset", outs(), pack(0, 8'h00, 1, 0, 0, 0, 16'd0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
